nd2latch_wr_sched: RTL and testbench
====================================

# nd2latch_wr_sched

Write scheduler for a bank of `WIDTH` ND2LATCH cells that share one EN/ENB pair. It arbitrates two write requesters round-robin and converts each granted write into a timed SETUP, PULSE and HOLD sequence on the complementary latch enables. It also provides a high-impedance window in which both enables are low, so the latch outputs float. It sits between the digital write clients and the latch bank; the latch bank's Q/QB outputs are not observed by this block.

## Interface
- `WIDTH`, 8: latches in the bank and write data width.
- `SETUP_CYC`, 1: cycles data is driven before EN rises, ≥1.
- `PULSE_CYC`, 2: cycles EN=1/ENB=0, ≥1.
- `HOLD_CYC`, 1: cycles data is held after EN falls, ≥1.

Ports:
- `CLK` in 1: clock; all logic on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `REQ0`, `REQ1` in 1: write requests; each is held high until its ACK.
- `WDATA0`, `WDATA1` in WIDTH: write data; stable while REQ is high.
- `ACK0`, `ACK1` out 1: one-cycle completion pulse.
- `BUSY` out 1: high in SETUP, PULSE and HOLD.
- `HIZ_REQ` in 1: request to float the latch outputs.
- `LAT_A0` out WIDTH: drives latch A0. Equals ~data while writing, so stored Q = data.
- `LAT_A1` out WIDTH: drives latch A1. All ones while writing.
- `LAT_EN`, `LAT_ENB` out 1: latch enable pair.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE
  - `LAT_EN`=0, `LAT_ENB`=1
  - `LAT_A0`='1, `LAT_A1`='0
  - `ACK0`/`ACK1`/`BUSY`=0
  - round-robin pointer favours REQ0
- Enable encoding per state:
  - IDLE: EN=0, ENB=1 (latch holds, outputs driven)
  - HIZ: EN=0, ENB=0 (outputs Z)
  - SETUP: EN=0, ENB=1
  - PULSE: EN=1, ENB=0
  - HOLD: EN=0, ENB=1
  - EN=1 with ENB=1 is never driven.
- State transitions:
  - IDLE: if any REQ, latch the winner's data into an internal register, drive `LAT_A0`=~data and `LAT_A1`='1, then go to SETUP. Else if `HIZ_REQ`, go to HIZ. Else stay.
  - HIZ: if any REQ, arbitrate as in IDLE and go to SETUP. Else if `HIZ_REQ`=0, go to IDLE.
  - SETUP → PULSE → HOLD: each state lasts its parameter count, tracked by a shared down-counter of width $clog2(max param + 1).
  - HOLD end: pulse ACK of the granted requester for one cycle, restore `LAT_A0`='1 and `LAT_A1`='0, go to IDLE.
- Arbitration:
  - If only one REQ is high, it wins.
  - If both are high, the requester not granted last wins; the pointer updates on each grant.
  - Write requests take priority over `HIZ_REQ`.
- Requests and `HIZ_REQ` are ignored while BUSY. A dropped REQ mid-sequence does not abort it; the ACK still fires.
- Hazard-free enables: from HIZ only ENB rises; from PULSE both enables change in the same edge from registers. EN and ENB are never both 1.
- RST mid-sequence: the next cycle returns to reset values with no ACK. The latch contents are then undefined and it is the requester's job to re-issue the write.

## Timing
- REQ sampled high at edge k in IDLE or HIZ:
  - SETUP covers cycles k+1 .. k+SETUP_CYC.
  - EN is high for PULSE_CYC cycles.
  - HOLD follows.
  - ACK is high in the single cycle after HOLD ends, at k+1+S+P+H.
  - The state is IDLE in that same cycle. The next request is sampled at edge k+1+S+P+H, so the minimum period between writes is S+P+H+1 cycles.
- With default parameters, write latency is 5 cycles from REQ to ACK.
- `HIZ_REQ` sampled at edge k in IDLE gives ENB=0 from cycle k+1.

## Structure
- Package `nd2latch_ctrl_pkg`:
  - state enum: IDLE, HIZ, SETUP, PULSE, HOLD
  - enable-pair constants per state
  - counter-width function
- Sub-module `rr_arb2` (combinational 2-way arbiter plus registered last-grant pointer): inputs req[1:0] and the update strobe; output one-hot grant.

## Test plan
- `REQ0` with `WDATA0`=8'hA5 in IDLE, defaults → `LAT_A0`=8'h5A and `LAT_A1`=8'hFF from k+1. EN=1/ENB=0 on cycles k+2..k+3. `ACK0` at k+5. Then `LAT_A0`=8'hFF.
- `REQ0` and `REQ1` asserted together, held after ACK → grants in order REQ0, REQ1, REQ0, with ACKs 5 cycles apart.
- `HIZ_REQ`=1 in IDLE → EN=ENB=0 next cycle. `REQ1`=1 during HIZ → EN=0/ENB=1 in SETUP, no cycle with EN=ENB=1, `ACK1` delivered.
- `RST` asserted in the second PULSE cycle → next cycle EN=0, ENB=1, `LAT_A0`='1, BUSY=0. No ACK is ever issued for that write.
- Parameters S=3, P=4, H=2 → EN high for exactly 4 cycles, ACK at k+10. Assertion: never EN&ENB.

Source files
------------

// File: rtl/nd2latch_ctrl_pkg.sv
// Shared types and constants for the ND2LATCH write scheduler.
// The enable-pair constants are packed as {en, enb}.
package nd2latch_ctrl_pkg;

  typedef enum logic [2:0] {StIdle, StHiz, StSetup, StPulse, StHold} state_e;

  localparam logic [1:0] EnIdle  = 2'b01;
  localparam logic [1:0] EnHiz   = 2'b00;
  localparam logic [1:0] EnSetup = 2'b01;
  localparam logic [1:0] EnPulse = 2'b10;
  localparam logic [1:0] EnHold  = 2'b01;

  function automatic int unsigned cnt_width(input int unsigned s, input int unsigned p,
                                            input int unsigned h);
    int unsigned m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nd2latch_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  // 1 when requester 1 was granted last; reset value makes requester 0 win a tie
  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (upd_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/nd2latch_wr_sched.sv
// Arbitrates two write clients and sequences SETUP/PULSE/HOLD on a shared EN/ENB latch pair,
// with an optional high-impedance window where both enables are low.
module nd2latch_wr_sched
  import nd2latch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] WDATA0,
  input  logic [WIDTH-1:0] WDATA1,
  input  logic             HIZ_REQ,
  output logic             ACK0,
  output logic             ACK1,
  output logic             BUSY,
  output logic [WIDTH-1:0] LAT_A0,
  output logic [WIDTH-1:0] LAT_A1,
  output logic             LAT_EN,
  output logic             LAT_ENB
);

  localparam int unsigned CntW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            sel_q;
  logic [1:0]      gnt;
  logic            start;

  assign start = ((state_q == StIdle) || (state_q == StHiz)) && (REQ0 || REQ1);

  rr_arb2 u_arb (
    .clk_i (CLK),
    .rst_i (RST),
    .req_i ({REQ1, REQ0}),
    .upd_i (start),
    .gnt_o (gnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      sel_q             <= 1'b0;
      {LAT_EN, LAT_ENB} <= EnIdle;
      LAT_A0            <= '1;
      LAT_A1            <= '0;
      ACK0              <= 1'b0;
      ACK1              <= 1'b0;
      BUSY              <= 1'b0;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      unique case (state_q)
        StIdle, StHiz: begin
          if (start) begin
            state_q           <= StSetup;
            cnt_q             <= CntW'(SETUP_CYC - 1);
            sel_q             <= gnt[1];
            LAT_A0            <= gnt[1] ? ~WDATA1 : ~WDATA0;
            LAT_A1            <= '1;
            BUSY              <= 1'b1;
            {LAT_EN, LAT_ENB} <= EnSetup;
          end else if ((state_q == StIdle) && HIZ_REQ) begin
            state_q           <= StHiz;
            {LAT_EN, LAT_ENB} <= EnHiz;
          end else if ((state_q == StHiz) && !HIZ_REQ) begin
            state_q           <= StIdle;
            {LAT_EN, LAT_ENB} <= EnIdle;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            state_q           <= StPulse;
            cnt_q             <= CntW'(PULSE_CYC - 1);
            {LAT_EN, LAT_ENB} <= EnPulse;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StPulse: begin
          // Both enables flip on the same edge, so EN and ENB never overlap high
          if (cnt_q == '0) begin
            state_q           <= StHold;
            cnt_q             <= CntW'(HOLD_CYC - 1);
            {LAT_EN, LAT_ENB} <= EnHold;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_q           <= StIdle;
            ACK0              <= ~sel_q;
            ACK1              <= sel_q;
            LAT_A0            <= '1;
            LAT_A1            <= '0;
            BUSY              <= 1'b0;
            {LAT_EN, LAT_ENB} <= EnIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q           <= StIdle;
          {LAT_EN, LAT_ENB} <= EnIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nd2latch_wr_sched.sv
// Bench for nd2latch_wr_sched: per-scenario tasks against a cycle-indexed reference model.
module tb_nd2latch_wr_sched;

  typedef struct packed {
    logic       en;
    logic       enb;
    logic       busy;
    logic       ack0;
    logic       ack1;
    logic [7:0] a0;
    logic [7:0] a1;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req0, req1, hiz;
  logic [7:0] wd0, wd1;
  logic       ack0, ack1, busy, en, enb;
  logic [7:0] a0, a1;

  logic       req2;
  logic [7:0] wd2;
  logic       ack2_0, ack2_1, busy2, en2, enb2;
  logic [7:0] a0_2, a1_2;

  int n_cmp = 0;
  int n_bad = 0;
  int hazard = 0;
  logic lastg;

  nd2latch_wr_sched dut (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .WDATA0(wd0), .WDATA1(wd1),
    .HIZ_REQ(hiz), .ACK0(ack0), .ACK1(ack1), .BUSY(busy), .LAT_A0(a0), .LAT_A1(a1),
    .LAT_EN(en), .LAT_ENB(enb)
  );

  nd2latch_wr_sched #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) dut2 (
    .CLK(clk), .RST(rst), .REQ0(req2), .REQ1(1'b0), .WDATA0(wd2), .WDATA1(8'h00),
    .HIZ_REQ(1'b0), .ACK0(ack2_0), .ACK1(ack2_1), .BUSY(busy2), .LAT_A0(a0_2), .LAT_A1(a1_2),
    .LAT_EN(en2), .LAT_ENB(enb2)
  );

  always @(negedge clk) begin
    if (((en & enb) === 1'b1) || ((en2 & enb2) === 1'b1)) hazard++;
  end

  // Expected outputs j cycles after the edge that accepted a write (j=0: idle, no write)
  function automatic obs_t model_cycle(int j, int s, int p, int h, logic g, logic [7:0] d);
    obs_t e;
    e = '{en: 1'b0, enb: 1'b1, busy: 1'b0, ack0: 1'b0, ack1: 1'b0, a0: 8'hFF, a1: 8'h00};
    if (j >= 1 && j <= s + p + h) begin
      e.busy = 1'b1;
      e.a0   = ~d;
      e.a1   = 8'hFF;
      if (j > s && j <= s + p) begin
        e.en  = 1'b1;
        e.enb = 1'b0;
      end
    end else if (j == s + p + h + 1) begin
      if (g) e.ack1 = 1'b1;
      else   e.ack0 = 1'b1;
    end
    return e;
  endfunction

  function automatic logic pick(logic r0, logic r1);
    if (r0 && r1) return ~lastg;
    return r1;
  endfunction

  function automatic obs_t obs1();
    return {en, enb, busy, ack0, ack1, a0, a1};
  endfunction

  function automatic obs_t obs2();
    return {en2, enb2, busy2, ack2_0, ack2_1, a0_2, a1_2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    lastg = 1'b1;
    e = model_cycle(0, 1, 2, 1, 1'b0, 8'h00);
    n_cmp++;
    if (obs1() !== e) begin
      n_bad++;
      $display("FAIL reset_dut got=%h exp=%h", obs1(), e);
    end
    n_cmp++;
    if (obs2() !== e) begin
      n_bad++;
      $display("FAIL reset_dut2 got=%h exp=%h", obs2(), e);
    end
  endtask

  task automatic test_single();
    obs_t e;
    req0 = 1'b1;
    wd0  = 8'hA5;
    step();
    lastg = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      e = model_cycle(j, 1, 2, 1, 1'b0, 8'hA5);
      n_cmp++;
      if (obs1() !== e) begin
        n_bad++;
        $display("FAIL single j=%0d got=%h exp=%h", j, obs1(), e);
      end
      if (j == 5) req0 = 1'b0;
      step();
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    logic g;
    logic [7:0] d;
    test_reset();
    wd0  = 8'h3C;
    wd1  = 8'hC7;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int t = 0; t < 3; t++) begin
      g = pick(req0, req1);
      lastg = g;
      d = g ? wd1 : wd0;
      step();
      for (int j = 1; j <= 5; j++) begin
        e = model_cycle(j, 1, 2, 1, g, d);
        n_cmp++;
        if (obs1() !== e) begin
          n_bad++;
          $display("FAIL b2b t=%0d j=%0d got=%h exp=%h", t, j, obs1(), e);
        end
        if (j < 5) step();
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    e = model_cycle(0, 1, 2, 1, 1'b0, 8'h00);
    n_cmp++;
    if (obs1() !== e) begin
      n_bad++;
      $display("FAIL b2b_idle got=%h exp=%h", obs1(), e);
    end
  endtask

  task automatic test_hiz();
    obs_t e;
    logic [7:0] d;
    int n;
    hiz = 1'b1;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      step();
      e = model_cycle(0, 1, 2, 1, 1'b0, 8'h00);
      e.enb = 1'b0;
      n_cmp++;
      if (obs1() !== e) begin
        n_bad++;
        $display("FAIL hiz_float i=%0d got=%h exp=%h", i, obs1(), e);
      end
    end
    d    = 8'($urandom);
    wd1  = d;
    req1 = 1'b1;
    step();
    lastg = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      e = model_cycle(j, 1, 2, 1, 1'b1, d);
      n_cmp++;
      if (obs1() !== e) begin
        n_bad++;
        $display("FAIL hiz_write j=%0d got=%h exp=%h", j, obs1(), e);
      end
      if (j == 5) begin
        req1 = 1'b0;
        hiz  = 1'b0;
      end
      step();
    end
    n_cmp++;
    if (hazard !== 0) begin
      n_bad++;
      $display("FAIL hiz_overlap got=%0d exp=0", hazard);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    logic [7:0] d;
    d    = 8'($urandom);
    wd0  = d;
    req0 = 1'b1;
    step();
    for (int j = 1; j <= 3; j++) begin
      e = model_cycle(j, 1, 2, 1, 1'b0, d);
      n_cmp++;
      if (obs1() !== e) begin
        n_bad++;
        $display("FAIL rstmid_pre j=%0d got=%h exp=%h", j, obs1(), e);
      end
      if (j < 3) step();
    end
    rst  = 1'b1;
    req0 = 1'b0;
    step();
    rst   = 1'b0;
    lastg = 1'b1;
    e = model_cycle(0, 1, 2, 1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs1() !== e) begin
        n_bad++;
        $display("FAIL rstmid_after i=%0d got=%h exp=%h", i, obs1(), e);
      end
      step();
    end
  endtask

  task automatic test_random();
    obs_t e;
    logic g;
    logic [7:0] d;
    int gap;
    for (int t = 0; t < 24; t++) begin
      if (!req0 && !req1) begin
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
          step();
          e = model_cycle(0, 1, 2, 1, 1'b0, 8'h00);
          n_cmp++;
          if (obs1() !== e) begin
            n_bad++;
            $display("FAIL rand_gap t=%0d got=%h exp=%h", t, obs1(), e);
          end
        end
      end
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1;
        wd0  = 8'($urandom);
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1'b1;
        wd1  = 8'($urandom);
      end
      if (!req0 && !req1) begin
        req0 = 1'b1;
        wd0  = 8'($urandom);
      end
      g = pick(req0, req1);
      lastg = g;
      d = g ? wd1 : wd0;
      step();
      for (int j = 1; j <= 5; j++) begin
        e = model_cycle(j, 1, 2, 1, g, d);
        n_cmp++;
        if (obs1() !== e) begin
          n_bad++;
          $display("FAIL rand t=%0d j=%0d got=%h exp=%h", t, j, obs1(), e);
        end
        hiz = (j < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (j == 5) begin
          if (g) req1 = 1'b0;
          else   req0 = 1'b0;
        end else begin
          step();
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    e = model_cycle(0, 1, 2, 1, 1'b0, 8'h00);
    n_cmp++;
    if (obs1() !== e) begin
      n_bad++;
      $display("FAIL rand_end got=%h exp=%h", obs1(), e);
    end
  endtask

  task automatic test_params();
    obs_t e;
    logic [7:0] d;
    int en_cycles;
    en_cycles = 0;
    d    = 8'($urandom);
    wd2  = d;
    req2 = 1'b1;
    step();
    for (int j = 1; j <= 11; j++) begin
      e = model_cycle(j, 3, 4, 2, 1'b0, d);
      n_cmp++;
      if (obs2() !== e) begin
        n_bad++;
        $display("FAIL params j=%0d got=%h exp=%h", j, obs2(), e);
      end
      if (en2 === 1'b1) en_cycles++;
      if (j == 10) req2 = 1'b0;
      step();
    end
    n_cmp++;
    if (en_cycles !== 4) begin
      n_bad++;
      $display("FAIL params_en_len got=%0d exp=4", en_cycles);
    end
    n_cmp++;
    if (hazard !== 0) begin
      n_bad++;
      $display("FAIL overlap got=%0d exp=0", hazard);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    hiz  = 1'b0;
    wd0  = 8'h00;
    wd1  = 8'h00;
    req2 = 1'b0;
    wd2  = 8'h00;
    lastg = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_hiz();
    test_reset_mid();
    test_random();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
